// File: rtl/pbkdf2_pkg.sv
// pbkdf2_pkg
// Shared constants, widths and the controller state type for the
// PBKDF2-HMAC-SHA256 iteration controller and its message builder.
package pbkdf2_pkg;

    localparam int          SALT_MAX_BYTES = 51;
    localparam int          U_BYTES        = 32;
    localparam logic [31:0] BLOCK_INDEX    = 32'h1;

    localparam int HMAC_KEY_W = 512;
    localparam int HMAC_MSG_W = 512;
    localparam int SALT_W     = SALT_MAX_BYTES * 8;
    localparam int PRF_W      = U_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/pbkdf2_msg_builder.sv
// pbkdf2_msg_builder
// Combinational formatter for the first HMAC message of a job:
// salt followed by the big-endian block index INT(1).
// Ports:
//   salt      in   SALT_W  salt, left-aligned, zero-filled on the right
//   salt_len  in   6       salt length in bytes
//   msg       out  512     salt || INT(1), left-aligned, zero-filled
//   msg_len   out  6       salt_len + 4
//   legal     out  1       salt_len is within 0..SALT_MAX_BYTES
module pbkdf2_msg_builder
    import pbkdf2_pkg::*;
(
    input  logic [SALT_W-1:0]     salt,
    input  logic [5:0]            salt_len,
    output logic [HMAC_MSG_W-1:0] msg,
    output logic [5:0]            msg_len,
    output logic                  legal
);

    logic [HMAC_MSG_W-1:0] idx_word;

    always_comb begin
        // Slide the 4-byte index right by salt_len bytes so it lands
        // immediately after the last salt byte.
        idx_word = {BLOCK_INDEX, {(HMAC_MSG_W - 32){1'b0}}} >> {salt_len, 3'b000};
        msg      = {salt, {(HMAC_MSG_W - SALT_W){1'b0}}} | idx_word;
        msg_len  = salt_len + 6'd4;
        legal    = (salt_len <= 6'(SALT_MAX_BYTES));
    end

endmodule

// File: rtl/pbkdf2_ctrl.sv
// pbkdf2_ctrl
// Runs PBKDF2-HMAC-SHA256 for derived-key block 1 by sequencing one
// external hmac_sha256 core: U1 = HMAC(P, S||INT(1)), Uj = HMAC(P, Uj-1),
// T = U1 ^ U2 ^ ... ^ Uc.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   v_i / r_o                    job handshake (password_i, salt_i,
//                                salt_len_i, iter_i sampled on accept)
//   dk_o, err_o / v_o, r_i       result handshake; err_o flags bad salt_len
//   hmac_key_o, hmac_msg_o,
//   hmac_len_o, hmac_v_o/hmac_r_i  request to the HMAC core
//   hmac_prf_i, hmac_v_i/hmac_r_o  response from the HMAC core
//   busy_o                       high outside IDLE
//
// state | meaning
// IDLE  | ready for a job
// ISSUE | presenting key/msg/len to the HMAC core
// WAIT  | waiting for the HMAC result, then accumulate
// DONE  | presenting dk_o/err_o until taken
module pbkdf2_ctrl
    import pbkdf2_pkg::*;
#(
    parameter int ITER_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  v_i,
    output logic                  r_o,
    input  logic [HMAC_KEY_W-1:0] password_i,
    input  logic [SALT_W-1:0]     salt_i,
    input  logic [5:0]            salt_len_i,
    input  logic [ITER_W-1:0]     iter_i,
    output logic [PRF_W-1:0]      dk_o,
    output logic                  err_o,
    output logic                  v_o,
    input  logic                  r_i,
    output logic [HMAC_KEY_W-1:0] hmac_key_o,
    output logic [HMAC_MSG_W-1:0] hmac_msg_o,
    output logic [5:0]            hmac_len_o,
    output logic                  hmac_v_o,
    input  logic                  hmac_r_i,
    input  logic [PRF_W-1:0]      hmac_prf_i,
    input  logic                  hmac_v_i,
    output logic                  hmac_r_o,
    output logic                  busy_o
);

    state_t state, state_nxt;

    logic [HMAC_KEY_W-1:0] key_q;
    logic [HMAC_MSG_W-1:0] msg_q;
    logic [5:0]            len_q;
    logic [PRF_W-1:0]      acc_q;
    logic [ITER_W-1:0]     cnt_q;
    logic [ITER_W-1:0]     c_q;
    logic                  err_q;

    logic [HMAC_MSG_W-1:0] u1_msg;
    logic [5:0]            u1_len;
    logic                  salt_ok;
    logic                  accept;
    logic [ITER_W-1:0]     cnt_inc;
    logic                  last_iter;

    pbkdf2_msg_builder u_msg_builder (
        .salt     (salt_i),
        .salt_len (salt_len_i),
        .msg      (u1_msg),
        .msg_len  (u1_len),
        .legal    (salt_ok)
    );

    // Kept independent of r_o so the FSM process has no feedback path.
    assign accept    = v_i & (state == IDLE) & ~rst_i;
    assign cnt_inc   = cnt_q + ITER_W'(1);
    assign last_iter = (cnt_inc == c_q);

    assign hmac_key_o = key_q;
    assign hmac_msg_o = msg_q;
    assign hmac_len_o = len_q;
    assign dk_o       = acc_q;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_o       = 1'b0;
        hmac_v_o  = 1'b0;
        hmac_r_o  = 1'b0;
        v_o       = 1'b0;
        busy_o    = (state != IDLE);
        case (state)
            IDLE: begin
                r_o = ~rst_i;
                if (accept) begin
                    state_nxt = salt_ok ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                hmac_v_o = 1'b1;
                if (hmac_r_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                hmac_r_o = 1'b1;
                if (hmac_v_i) begin
                    state_nxt = last_iter ? DONE : ISSUE;
                end
            end
            DONE: begin
                v_o = 1'b1;
                if (r_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q <= '0;
            msg_q <= '0;
            len_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            c_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_q <= password_i;
                        c_q   <= (iter_i == '0) ? ITER_W'(1) : iter_i;
                        acc_q <= '0;
                        cnt_q <= '0;
                        msg_q <= u1_msg;
                        len_q <= u1_len;
                        err_q <= ~salt_ok;
                    end
                end
                WAIT: begin
                    if (hmac_v_i) begin
                        acc_q <= acc_q ^ hmac_prf_i;
                        cnt_q <= cnt_inc;
                        // Next message is the previous U, left-aligned.
                        msg_q <= {hmac_prf_i, {(HMAC_MSG_W - PRF_W){1'b0}}};
                        len_q <= 6'(U_BYTES);
                    end
                end
                DONE: begin
                    if (r_i) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pbkdf2_ctrl.sv
module tb_pbkdf2_ctrl;

    localparam int ITER_W = 32;

    localparam logic [511:0] PW_PASSWORD = {64'h70617373776f7264, 448'b0};
    localparam logic [407:0] SALT_SALT   = {32'h73616c74, 376'b0};
    localparam logic [255:0] DK_C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK_C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK_C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              v_i;
    logic              r_o;
    logic [511:0]      password_i;
    logic [407:0]      salt_i;
    logic [5:0]        salt_len_i;
    logic [ITER_W-1:0] iter_i;
    logic [255:0]      dk_o;
    logic              err_o;
    logic              v_o;
    logic              r_i;
    logic [511:0]      hmac_key_o;
    logic [511:0]      hmac_msg_o;
    logic [5:0]        hmac_len_o;
    logic              hmac_v_o;
    logic              hmac_r_i;
    logic [255:0]      hmac_prf_i;
    logic              hmac_v_i;
    logic              hmac_r_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    int rdy_delay_cfg = -1;
    int lat_cfg       = -1;
    int xfer_cnt      = 0;
    logic [511:0] msg_log [$];
    logic [5:0]   len_log [$];

    pbkdf2_ctrl #(.ITER_W(ITER_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .v_i        (v_i),
        .r_o        (r_o),
        .password_i (password_i),
        .salt_i     (salt_i),
        .salt_len_i (salt_len_i),
        .iter_i     (iter_i),
        .dk_o       (dk_o),
        .err_o      (err_o),
        .v_o        (v_o),
        .r_i        (r_i),
        .hmac_key_o (hmac_key_o),
        .hmac_msg_o (hmac_msg_o),
        .hmac_len_o (hmac_len_o),
        .hmac_v_o   (hmac_v_o),
        .hmac_r_i   (hmac_r_i),
        .hmac_prf_i (hmac_prf_i),
        .hmac_v_i   (hmac_v_i),
        .hmac_r_o   (hmac_r_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference SHA-256 / HMAC / PBKDF2 ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Key fits one block; message of up to 55 bytes always pads into one block.
    function automatic logic [255:0] hmac_ref(input logic [511:0] key, input logic [511:0] msg,
                                              input int len);
        logic [511:0] mask, blk;
        logic [255:0] ih;
        mask = {512{1'b1}};
        mask = ~(mask >> (8 * len));
        blk = msg & mask;
        blk[511 - 8*len -: 8] = 8'h80;
        blk[63:0] = 64'((64 + len) * 8);
        ih = sha_blk(sha_blk(SHA_IV, key ^ {64{8'h36}}), blk);
        return sha_blk(sha_blk(SHA_IV, key ^ {64{8'h5c}}), {ih, 8'h80, 184'b0, 64'd768});
    endfunction

    function automatic logic [255:0] pbkdf2_ref(input logic [511:0] pw, input logic [407:0] salt,
                                                input int slen, input logic [31:0] c);
        logic [511:0] m;
        logic [255:0] u, t;
        int n;
        m = {salt, 104'b0};
        for (int b = 0; b < 4; b++) m[511 - 8*(slen + b) -: 8] = (b == 3) ? 8'h01 : 8'h00;
        u = hmac_ref(pw, m, slen + 4);
        t = u;
        n = (c == 0) ? 1 : int'(c);
        for (int j = 1; j < n; j++) begin
            u = hmac_ref(pw, {u, 256'b0}, 32);
            t = t ^ u;
        end
        return t;
    endfunction

    function automatic logic [511:0] rand_left(input int nbytes);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < nbytes; i++) r[511 - 8*i -: 8] = 8'($urandom);
        return r;
    endfunction

    // ---------------- HMAC core stand-in ----------------
    initial begin : responder
        int phase;
        int cnt;
        bit seen;
        logic [255:0] prf_pending;
        hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
        phase = 0; cnt = -1; seen = 1'b0; prf_pending = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
                phase = 0; cnt = -1;
            end else begin
                case (phase)
                    0: if (hmac_v_o) begin
                        if (cnt < 0) cnt = (rdy_delay_cfg >= 0) ? rdy_delay_cfg : int'($urandom_range(0, 2));
                        if (cnt == 0) begin
                            hmac_r_i = 1'b1;
                            msg_log.push_back(hmac_msg_o);
                            len_log.push_back(hmac_len_o);
                            prf_pending = hmac_ref(hmac_key_o, hmac_msg_o, int'(hmac_len_o));
                            xfer_cnt++;
                            phase = 1;
                        end else begin
                            cnt--;
                        end
                    end
                    1: begin
                        hmac_r_i = 1'b0;
                        cnt = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 2));
                        phase = 2;
                    end
                    2: if (cnt == 0) begin
                        hmac_v_i = 1'b1;
                        hmac_prf_i = prf_pending;
                        seen = hmac_r_o;
                        phase = 3;
                    end else begin
                        cnt--;
                    end
                    default: if (seen) begin
                        hmac_v_i = 1'b0;
                        hmac_prf_i = '0;
                        phase = 0;
                        cnt = -1;
                    end else begin
                        seen = hmac_r_o;
                    end
                endcase
            end
        end
    end

    // ---------------- job driver ----------------
    // Returns on the negedge one cycle after the accept edge.
    task automatic start_job(input logic [511:0] pw, input logic [407:0] salt, input logic [5:0] slen,
                             input logic [31:0] c);
        bit ok;
        @(negedge clk_i);
        v_i = 1'b1; password_i = pw; salt_i = salt; salt_len_i = slen; iter_i = c;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (r_o) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL job_accept_timeout: r_o=%0b, required 1 within 50 cycles", r_o);
        end
        @(negedge clk_i);
        v_i = 1'b0;
        password_i = rand_left(64);
        salt_i = 408'($urandom);
        salt_len_i = 6'($urandom);
        iter_i = $urandom;
    endtask

    task automatic wait_result(output logic [255:0] dk, output logic err);
        int n;
        n = 0;
        while (!v_o && n < 60000) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (!v_o) begin
            n_fail++;
            $display("FAIL result_timeout: v_o=%0b, required 1 within 60000 cycles", v_o);
        end
        dk = dk_o;
        err = err_o;
    endtask

    task automatic complete_job();
        r_i = 1'b1;
        @(negedge clk_i);
        r_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        v_i = 1'b0; r_i = 1'b0; password_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({r_o, v_o, hmac_v_o, hmac_r_o, busy_o, err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: r/v/hv/hr/busy/err=%b, required 000000",
                     {r_o, v_o, hmac_v_o, hmac_r_o, busy_o, err_o});
        end
        n_checks++;
        if (dk_o !== '0) begin
            n_fail++;
            $display("FAIL reset_dk: got %h, required 0", dk_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (r_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: r_o=%0b busy_o=%0b, required 1 0", r_o, busy_o);
        end
    endtask

    task automatic test_known_vectors();
        logic [255:0] dk;
        logic err;
        int base;
        logic [31:0] cs [4] = '{32'd1, 32'd2, 32'd0, 32'd4096};
        logic [255:0] ex [4] = '{DK_C1, DK_C2, DK_C1, DK_C4096};
        int nx [4] = '{1, 2, 1, 4096};
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin rdy_delay_cfg = 0; lat_cfg = 0; end
            base = xfer_cnt;
            msg_log.delete(); len_log.delete();
            start_job(PW_PASSWORD, SALT_SALT, 6'd4, cs[k]);
            n_checks++;
            if (hmac_v_o !== 1'b1) begin
                n_fail++;
                $display("FAIL kv%0d_issue_latency: hmac_v_o=%0b one cycle after accept, required 1", k, hmac_v_o);
            end
            wait_result(dk, err);
            n_checks++;
            if (dk !== ex[k] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL kv%0d_dk: got %h err %0b, required %h err 0", k, dk, err, ex[k]);
            end
            n_checks++;
            if (xfer_cnt - base != nx[k]) begin
                n_fail++;
                $display("FAIL kv%0d_xfers: got %0d, required %0d", k, xfer_cnt - base, nx[k]);
            end
            if (k == 0) begin
                n_checks++;
                if (msg_log[0] !== {32'h73616c74, 32'h00000001, 448'b0} || len_log[0] !== 6'd8) begin
                    n_fail++;
                    $display("FAIL kv_u1_msg: got %h len %0d, required salt||INT(1) len 8", msg_log[0], len_log[0]);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (msg_log[1] !== {DK_C1, 256'b0} || len_log[1] !== 6'd32) begin
                    n_fail++;
                    $display("FAIL kv_u2_msg: got %h len %0d, required U1||0 len 32", msg_log[1], len_log[1]);
                end
            end
            complete_job();
        end
        rdy_delay_cfg = -1; lat_cfg = -1;
    endtask

    task automatic test_salt_boundaries();
        logic [511:0] pw, sfull;
        logic [255:0] dk, exp_dk;
        logic err;
        int base;
        pw = rand_left(20);
        sfull = rand_left(51);
        exp_dk = pbkdf2_ref(pw, sfull[511:104], 51, 32'd2);
        msg_log.delete(); len_log.delete();
        start_job(pw, sfull[511:104], 6'd51, 32'd2);
        wait_result(dk, err);
        n_checks++;
        if (len_log[0] !== 6'd55 || msg_log[0][511-8*51 -: 32] !== 32'h00000001) begin
            n_fail++;
            $display("FAIL salt51_msg: len %0d index %h, required 55 00000001", len_log[0], msg_log[0][511-8*51 -: 32]);
        end
        n_checks++;
        if (dk !== exp_dk || err !== 1'b0) begin
            n_fail++;
            $display("FAIL salt51_dk: got %h err %0b, required %h err 0", dk, err, exp_dk);
        end
        complete_job();

        base = xfer_cnt;
        start_job(pw, sfull[511:104], 6'd52, 32'd3);
        n_checks++;
        if (v_o !== 1'b1 || err_o !== 1'b1 || dk_o !== '0 || hmac_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL salt52_result: v_o %0b err %0b dk %h hmac_v %0b, required 1 1 0 0",
                     v_o, err_o, dk_o, hmac_v_o);
        end
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (xfer_cnt != base || v_o !== 1'b1 || r_o !== 1'b0) begin
            n_fail++;
            $display("FAIL salt52_hold: xfers %0d v_o %0b r_o %0b, required 0 1 0", xfer_cnt - base, v_o, r_o);
        end
        complete_job();
        n_checks++;
        if (err_o !== 1'b0 || r_o !== 1'b1) begin
            n_fail++;
            $display("FAIL salt52_clear: err_o %0b r_o %0b, required 0 1", err_o, r_o);
        end
    endtask

    task automatic test_hmac_backpressure();
        logic [511:0] pw, m0;
        logic [255:0] dk, exp_dk;
        logic err;
        bit bad;
        pw = rand_left(33);
        exp_dk = pbkdf2_ref(pw, SALT_SALT, 4, 32'd2);
        rdy_delay_cfg = 5; lat_cfg = 0;
        start_job(pw, SALT_SALT, 6'd4, 32'd2);
        #1;
        m0 = hmac_msg_o;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk_i); #1; end
            if (hmac_v_o !== 1'b1 || hmac_msg_o !== m0 || hmac_len_o !== 6'd8 || hmac_key_o !== pw) bad = 1'b1;
            if (k < 5 && hmac_r_i !== 1'b0) bad = 1'b1;
        end
        rdy_delay_cfg = -1; lat_cfg = -1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL hmac_bp_stable: hmac_v_o %0b len %0d msg %h, required held 1/8/constant",
                     hmac_v_o, hmac_len_o, hmac_msg_o);
        end
        wait_result(dk, err);
        n_checks++;
        if (dk !== exp_dk) begin
            n_fail++;
            $display("FAIL hmac_bp_dk: got %h, required %h", dk, exp_dk);
        end
        complete_job();
    endtask

    task automatic test_result_backpressure();
        logic [511:0] pw, s;
        logic [255:0] dk, exp_dk;
        logic err;
        bit bad;
        pw = rand_left(12);
        s = rand_left(9);
        exp_dk = pbkdf2_ref(pw, s[511:104], 9, 32'd3);
        start_job(pw, s[511:104], 6'd9, 32'd3);
        wait_result(dk, err);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (v_o !== 1'b1 || dk_o !== dk || r_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL res_bp_stable: v_o %0b r_o %0b dk %h, required 1 0 held", v_o, r_o, dk_o);
        end
        n_checks++;
        if (dk !== exp_dk) begin
            n_fail++;
            $display("FAIL res_bp_dk: got %h, required %h", dk, exp_dk);
        end
        complete_job();
    endtask

    task automatic test_random();
        logic [511:0] pw, s;
        logic [255:0] dk, exp_dk;
        logic err, exp_err;
        int slen, base, exp_x;
        logic [31:0] c;
        for (int j = 0; j < 10; j++) begin
            pw = rand_left(int'($urandom_range(1, 64)));
            slen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(52, 63)) : int'($urandom_range(0, 51));
            s = rand_left((slen > 51) ? 51 : slen);
            c = $urandom_range(0, 5);
            exp_err = (slen > 51);
            exp_dk = exp_err ? 256'b0 : pbkdf2_ref(pw, s[511:104], slen, c);
            exp_x = exp_err ? 0 : ((c == 0) ? 1 : int'(c));
            base = xfer_cnt;
            start_job(pw, s[511:104], 6'(slen), c);
            wait_result(dk, err);
            n_checks++;
            if (dk !== exp_dk || err !== exp_err || xfer_cnt - base != exp_x) begin
                n_fail++;
                $display("FAIL rand%0d: dk %h err %0b xfers %0d, required %h err %0b xfers %0d",
                         j, dk, err, xfer_cnt - base, exp_dk, exp_err, exp_x);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            complete_job();
        end
    endtask

    task automatic test_reset_mid_job();
        logic [255:0] dk;
        logic err;
        int base, n;
        base = xfer_cnt;
        start_job(rand_left(16), SALT_SALT, 6'd4, 32'd8);
        n = 0;
        #1;
        while (!(xfer_cnt - base == 3 && hmac_r_o === 1'b1) && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL midrst_reach_wait3: xfers %0d hmac_r_o %0b, required 3 1", xfer_cnt - base, hmac_r_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({r_o, v_o, hmac_v_o, hmac_r_o, busy_o, err_o} !== 6'b0 || dk_o !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: r/v/hv/hr/busy/err=%b dk %h, required 000000 and 0",
                     {r_o, v_o, hmac_v_o, hmac_r_o, busy_o, err_o}, dk_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (r_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: r_o %0b, required 1", r_o);
        end
        base = xfer_cnt;
        start_job(PW_PASSWORD, SALT_SALT, 6'd4, 32'd1);
        wait_result(dk, err);
        n_checks++;
        if (dk !== DK_C1 || err !== 1'b0 || xfer_cnt - base != 1) begin
            n_fail++;
            $display("FAIL midrst_fresh: dk %h err %0b xfers %0d, required %h 0 1", dk, err, xfer_cnt - base, DK_C1);
        end
        complete_job();
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_salt_boundaries();
        test_hmac_backpressure();
        test_result_backpressure();
        test_random();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
